// File: rtl/fetch_prefetch_buffer_if.sv
// CPU fetch port and ROM read port of the prefetcher, both 4-phase trigger/ready.
// slave is the prefetcher's view; master is the cpu + ROM side driving it.
interface fetch_prefetch_buffer_if;
  logic [31:0] addrIn;
  logic        triggerIn;
  logic [31:0] dataOut;
  logic        readyOut;
  logic [31:0] addrOutRF;
  logic        triggerOutRF;
  logic [31:0] dataInRF;
  logic        readyInRF;

  modport slave (
    input  addrIn, triggerIn, dataInRF, readyInRF,
    output dataOut, readyOut, addrOutRF, triggerOutRF
  );

  modport master (
    output addrIn, triggerIn, dataInRF, readyInRF,
    input  dataOut, readyOut, addrOutRF, triggerOutRF
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher: tagged FIFO between cpu fetch port and ROM; hit acks SYNC_STAGES+1 edges after triggerIn is sampled.
// Prefetch stalls when stored + in-flight words reach DEPTH; a cpu miss flushes and waits for the redirected read.
module fetch_prefetch_buffer #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_STEP   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} rom_st_t;
  typedef enum logic [1:0] {C_IDLE, C_LOOK, C_WAIT, C_ACK} cpu_st_t;

  rom_st_t r_rom_st, w_rom_nxt;
  cpu_st_t r_cpu_st, w_cpu_nxt;

  logic [SYNC_STAGES-1:0] r_trig_sync, r_rdy_sync, r_warm;
  entry_t                 r_mem [DEPTH];
  logic [PW-1:0]          r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [31:0]            r_fetch_addr, r_addr_rf, r_data_out;
  logic                   r_trig_rf, r_ready, r_stale;

  logic          w_trig_s, w_rdy_s, w_armed;
  logic [CW-1:0] w_occ;
  logic          w_issue, w_rom_done, w_push, w_pop, w_flush, w_load;
  logic          w_hit, w_inflight_live, w_pending_ok;

  assign w_trig_s = r_trig_sync[SYNC_STAGES-1];
  assign w_rdy_s  = r_rdy_sync[SYNC_STAGES-1];
  // The synchronizers clear on reset, so a zero is only trusted once they have refilled.
  assign w_armed  = r_warm[SYNC_STAGES-1];

  assign w_occ           = r_count + CW'(r_rom_st == R_REQ);
  assign w_rom_done      = (r_rom_st == R_REQ) && w_rdy_s;
  assign w_push          = w_rom_done && !r_stale && !w_flush;
  assign w_issue         = (r_rom_st == R_IDLE) && (w_occ < CW'(DEPTH)) && !w_rdy_s
                           && w_armed && !w_flush;
  assign w_hit           = (r_count != '0) && (r_mem[r_rd_ptr].addr == bus.addrIn);
  assign w_inflight_live = (r_rom_st == R_REQ) && !r_stale;
  assign w_pending_ok    = (r_count == '0) &&
                           (w_inflight_live ? (r_addr_rf == bus.addrIn)
                                            : (r_fetch_addr == bus.addrIn));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trig_sync <= '0;
      r_rdy_sync  <= '0;
      r_warm      <= '0;
    end else begin
      r_trig_sync[0] <= bus.triggerIn;
      r_rdy_sync[0]  <= bus.readyInRF;
      r_warm[0]      <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_trig_sync[i] <= r_trig_sync[i-1];
        r_rdy_sync[i]  <= r_rdy_sync[i-1];
        r_warm[i]      <= r_warm[i-1];
      end
    end
  end

  always_comb begin
    w_rom_nxt = r_rom_st;
    case (r_rom_st)
      R_IDLE:  if (w_issue)  w_rom_nxt = R_REQ;
      R_REQ:   if (w_rdy_s)  w_rom_nxt = R_REL;
      R_REL:   if (!w_rdy_s) w_rom_nxt = R_IDLE;
      default: w_rom_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_cpu_nxt = r_cpu_st;
    w_load    = 1'b0;
    w_flush   = 1'b0;
    w_pop     = 1'b0;
    case (r_cpu_st)
      C_IDLE: if (w_trig_s) w_cpu_nxt = C_LOOK;
      C_LOOK: begin
        if (w_hit) begin
          w_load    = 1'b1;
          w_cpu_nxt = C_ACK;
        end else if (w_pending_ok) begin
          w_cpu_nxt = C_WAIT;
        end else begin
          w_flush   = 1'b1;
          w_cpu_nxt = C_WAIT;
        end
      end
      C_WAIT: begin
        if (w_hit) begin
          w_load    = 1'b1;
          w_cpu_nxt = C_ACK;
        end else if (r_count != '0) begin
          w_cpu_nxt = C_LOOK;
        end
      end
      C_ACK: begin
        if (!w_trig_s) begin
          w_pop     = 1'b1;
          w_cpu_nxt = C_IDLE;
        end
      end
      default: w_cpu_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rom_st     <= R_IDLE;
      r_cpu_st     <= C_IDLE;
      r_fetch_addr <= '0;
      r_addr_rf    <= '0;
      r_trig_rf    <= 1'b0;
      r_stale      <= 1'b0;
      r_ready      <= 1'b0;
      r_data_out   <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_rom_st <= w_rom_nxt;
      r_cpu_st <= w_cpu_nxt;

      if (w_issue) begin
        r_addr_rf <= r_fetch_addr;
        r_trig_rf <= 1'b1;
      end else if (w_rom_done) begin
        r_trig_rf <= 1'b0;
      end

      // A redirect wins over the sequential advance; a discarded read must not advance either.
      if (w_flush)
        r_fetch_addr <= bus.addrIn;
      else if (w_rom_done && !r_stale)
        r_fetch_addr <= r_fetch_addr + 32'(ADDR_STEP);

      if (w_rom_done)
        r_stale <= 1'b0;
      else if (w_flush && (r_rom_st == R_REQ))
        r_stale <= 1'b1;

      if (w_load) begin
        r_ready    <= 1'b1;
        r_data_out <= r_mem[r_rd_ptr].data;
      end else if (w_pop) begin
        r_ready <= 1'b0;
      end

      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: r_fetch_addr, data: bus.dataInRF};
  end

  assign bus.addrOutRF    = r_addr_rf;
  assign bus.triggerOutRF = r_trig_rf;
  assign bus.readyOut     = r_ready;
  assign bus.dataOut      = r_data_out;
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench: ROM responder returning addr^KEY, randomized cpu fetch stream checked against word_of(addr).
module tb_fetch_prefetch_buffer;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_buffer_if bus ();

  fetch_prefetch_buffer #(.DEPTH(4), .SYNC_STAGES(2), .ADDR_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          rom_lat = 3;
  int          rom_hold = 0;
  int          proto_viol = 0;
  logic [31:0] rom_log[$];
  logic        prev_trig = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic logic [31:0] log_at(int i);
    if (i >= 0 && i < rom_log.size()) return rom_log[i];
    return 32'hDEADBEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ROM model: answers each request after rom_lat cycles, keeps ready high rom_hold cycles after release.
  initial begin : rom_model
    logic [31:0] a;
    int          lat, hold;
    bus.dataInRF  = '0;
    bus.readyInRF = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.triggerOutRF === 1'b1 && bus.readyInRF == 1'b0) begin
        a   = bus.addrOutRF;
        lat = rom_lat;
        repeat (lat) @(posedge clk);
        #1;
        rom_log.push_back(a);
        bus.dataInRF  = word_of(a);
        bus.readyInRF = 1'b1;
        while (bus.triggerOutRF === 1'b1) begin
          @(posedge clk); #1;
        end
        hold = rom_hold;
        repeat (hold) @(posedge clk);
        #1;
        bus.readyInRF = 1'b0;
        bus.dataInRF  = $urandom;
      end
    end
  end

  // Request must not rise while ROM still acks, and address holds while the request is up.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.triggerOutRF && !prev_trig && bus.readyInRF) proto_viol++;
      if (bus.triggerOutRF && prev_trig && bus.addrOutRF != prev_addr) proto_viol++;
    end
    prev_trig = bus.triggerOutRF;
    prev_addr = bus.addrOutRF;
  end

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    logic got, rel;
    got = 1'b0;
    rel = 1'b0;
    lat = -1;
    d   = '0;
    @(negedge clk);
    bus.addrIn    = a;
    bus.triggerIn = 1'b1;
    for (int k = 1; k <= 600 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.readyOut) begin
        got = 1'b1;
        lat = k - 1;
        d   = bus.dataOut;
      end
    end
    chk("fetch_ack", {31'b0, got}, 32'd1);
    bus.triggerIn = 1'b0;
    for (int k = 0; k < 50 && !rel; k++) begin
      @(posedge clk); #1;
      if (!bus.readyOut) rel = 1'b1;
    end
    chk("fetch_release", {31'b0, rel}, 32'd1);
  endtask

  task automatic fetch_chk(input logic [31:0] a);
    logic [31:0] d;
    int          lat;
    do_fetch(a, d, lat);
    chk("fetch_data", d, word_of(a));
  endtask

  initial begin : main
    logic [31:0] d, cur;
    int          lat, base, idx;
    logic        found;
    bus.addrIn    = '0;
    bus.triggerIn = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_readyOut", {31'b0, bus.readyOut}, 32'd0);
    chk("rst_trigRF", {31'b0, bus.triggerOutRF}, 32'd0);
    chk("rst_dataOut", bus.dataOut, 32'd0);
    chk("rst_addrRF", bus.addrOutRF, 32'd0);
    reset = 1'b1;

    // Idle cpu: buffer fills to exactly DEPTH words then prefetch stops.
    repeat (100) @(posedge clk);
    #1;
    chk("fill_count", 32'(rom_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_addr", log_at(i), 32'(4 * i));
    chk("fill_idle_trig", {31'b0, bus.triggerOutRF}, 32'd0);

    // Hit latency on a prefilled buffer; the pop releases exactly one new read (held slow).
    rom_lat = 40;
    do_fetch(32'h0, d, lat);
    chk("fetch_data", d, word_of(32'h0));
    chk("hit_latency", 32'(lat), 32'd3);
    repeat (10) @(posedge clk);
    #1;
    chk("one_more_count", 32'(rom_log.size()), 32'd4);
    chk("one_more_addr", bus.addrOutRF, 32'h10);
    chk("one_more_trig", {31'b0, bus.triggerOutRF}, 32'd1);
    fetch_chk(32'h4);
    rom_lat = 3;

    // Branch while 0x10 is in flight: it completes, is discarded, then 0x100 is read.
    fetch_chk(32'h100);
    chk("flush_seq0", log_at(4), 32'h10);
    chk("flush_seq1", log_at(5), 32'h100);

    // Address wrap across the top of the 32-bit space.
    base = rom_log.size();
    fetch_chk(32'hFFFF_FFF8);
    fetch_chk(32'hFFFF_FFFC);
    fetch_chk(32'h0000_0000);
    idx = -1;
    for (int i = base; i < rom_log.size(); i++)
      if (idx < 0 && rom_log[i] == 32'hFFFF_FFF8) idx = i;
    chk("wrap_seq0", log_at(idx), 32'hFFFF_FFF8);
    chk("wrap_seq1", log_at(idx + 1), 32'hFFFF_FFFC);
    chk("wrap_seq2", log_at(idx + 2), 32'h0000_0000);

    // Random fetch stream: mostly sequential, occasional branches, random ROM latency and cpu gaps.
    cur = 32'h4;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) cur = $urandom & 32'hFFFF_FFFC;
      rom_lat = $urandom_range(1, 6);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      fetch_chk(cur);
      cur = cur + 32'd4;
    end

    // Reset while a ROM handshake is in its acknowledged phase.
    rom_lat = 3;
    fetch_chk(32'h200);
    rom_hold = 12;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (bus.triggerOutRF && bus.readyInRF) found = 1'b1;
    end
    chk("rst_window", {31'b0, found}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_trigRF", {31'b0, bus.triggerOutRF}, 32'd0);
    chk("midrst_readyOut", {31'b0, bus.readyOut}, 32'd0);
    chk("midrst_addrRF", bus.addrOutRF, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rom_log.delete();
    reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (bus.triggerOutRF) begin
        found = 1'b1;
        chk("post_rst_rdy_low", {31'b0, bus.readyInRF}, 32'd0);
        chk("post_rst_addr", bus.addrOutRF, 32'd0);
      end
    end
    chk("post_rst_issue", {31'b0, found}, 32'd1);
    rom_hold = 0;
    for (int k = 0; k < 300 && rom_log.size() < 4; k++) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("post_rst_seq", log_at(i), 32'(4 * i));

    // Plain sequential stream after reset.
    fetch_chk(32'h0);
    fetch_chk(32'h4);
    fetch_chk(32'h8);
    fetch_chk(32'hC);

    chk("rom_protocol", 32'(proto_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Clocked instruction prefetcher between the cpu fetch port and the instruction ROM.
- On the ROM side it issues sequential word reads using the 4-phase trigger/ready handshake.
- It holds prefetched words in a small tagged FIFO and answers cpu fetch requests over the same 4-phase handshake.
- A fetch to a non-sequential address (branch) flushes the buffer and restarts prefetch from that address.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- SYNC_STAGES, 2, flops in each input synchronizer (triggerIn, readyInRF)
- ADDR_STEP, 4, byte increment between sequential fetches

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- addrIn  input  32  cpu fetch address, stable while triggerIn high
- triggerIn  input  1  cpu fetch request (4-phase)
- dataOut  output  32  instruction word for addrIn
- readyOut  output  1  fetch acknowledge (4-phase)
- addrOutRF  output  32  ROM read address
- triggerOutRF  output  1  ROM request (4-phase)
- dataInRF  input  32  ROM data, valid while readyInRF high
- readyInRF  input  1  ROM acknowledge (4-phase)

Behaviour:
- Reset (reset=0, async):
  - readyOut=0, triggerOutRF=0, dataOut=0, addrOutRF=0.
  - FIFO empty, fetch_addr=0, synchronizers cleared.
  - Both FSMs return to idle.
- Synchronization:
  - triggerIn and readyInRF each pass through SYNC_STAGES flops before use.
  - addrIn and dataInRF are sampled only after their synchronized qualifier is high.
- FIFO:
  - Each entry holds {addr[31:0], data[31:0]}.
  - Head entry is a hit when head.addr==addrIn.
  - Occupancy counts stored entries plus one in-flight ROM read; prefetch issues only when occupancy<DEPTH.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- ROM FSM:
  - R_IDLE -> R_REQ when occupancy<DEPTH and synced readyInRF=0.
    - On entry: addrOutRF<=fetch_addr, triggerOutRF<=1.
  - R_REQ -> R_REL when synced readyInRF=1.
    - Capture dataInRF; push {fetch_addr, data} unless the read is marked stale.
    - triggerOutRF<=0; fetch_addr<=fetch_addr+ADDR_STEP (32-bit wrap, 0xFFFFFFFC->0x00000000).
  - R_REL -> R_IDLE when synced readyInRF=0.
  - addrOutRF is held constant from R_REQ entry until R_IDLE.
- CPU FSM:
  - C_IDLE -> C_LOOK on synced triggerIn=1.
  - C_LOOK:
    - Hit: dataOut<=head.data, readyOut<=1, go to C_ACK.
    - Empty and no flush needed, with the in-flight read or next fetch_addr equal to addrIn: go to C_WAIT.
    - Otherwise (miss): flush FIFO, mark any in-flight ROM read stale, fetch_addr<=addrIn, go to C_WAIT.
  - C_WAIT: re-evaluate a hit every cycle; on hit act as in C_LOOK.
  - C_ACK -> C_IDLE on synced triggerIn=0: readyOut<=0, pop head.
- Hit latency: readyOut rises SYNC_STAGES+1 clock edges after the first edge that samples triggerIn high.
- Flush rules:
  - An in-flight ROM transaction is never aborted; it completes all 4 phases and its data is discarded.
  - The new fetch_addr is issued afterwards.
  - Flush and push in the same cycle: the flush wins and the push is dropped.
- dataOut is held from readyOut rise until the next C_LOOK hit.
- triggerIn dropping before readyOut is a cpu protocol violation; behaviour is undefined.
- Reset mid-transaction:
  - triggerOutRF and readyOut drop immediately.
  - After release, the ROM FSM waits for synced readyInRF=0 before issuing.

Test Plan:
- Reset, ROM returns data=addr^0xA5A5A5A5 with 3-cycle latency; cpu fetches 0x0,0x4,0x8,0xC -> dataOut 0xA5A5A5A5,0xA5A5A5A1,0xA5A5A5AD,0xA5A5A5A9 in order, addrOutRF sequence 0x0,0x4,0x8,...
- Cpu idle long enough -> exactly DEPTH=4 ROM reads (0x0-0xC) issued, then triggerOutRF stays 0; one pop -> exactly one further read at 0x10.
- After fetching 0x0 and 0x4, cpu fetches 0x100 while read of 0x10 is in flight -> 0x10 handshake completes, its data is not returned, next addrOutRF=0x100, dataOut=word(0x100).
- FIFO prefilled, cpu hit on 0x0 -> readyOut high exactly 3 edges after the first edge sampling triggerIn=1.
- fetch_addr seeded via branch to 0xFFFFFFF8 -> reads 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; all three fetches hit.
- Assert reset=0 while triggerOutRF=1 and readyInRF=1 -> triggerOutRF=0 and readyOut=0 immediately; after release no new request until readyInRF=0, then first addrOutRF=0x0.
